unidad_control_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-cycle control decoder.
- Decodes OPCODE/ALUOP in ID and registers the control bundle through EX, MEM and WB stage registers, so each stage consumes its own signals.
- Adds stall (bubble insertion), flush (branch kill), per-stage valid bits, and illegal-opcode detection with a saturating counter.

---
 rtl/unidad_control_pipe_if.sv | 50 +++++
 rtl/unidad_control_pipe.sv | 134 +++++++++++++
 tb/tb_unidad_control_pipe.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/unidad_control_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : unidad_control_pipe_if
// Brief    : ID-stage inputs and per-stage control outputs of the pipelined
//            control unit, bundled for the decoder and its driver.
// Revision : 1.0 - initial release
// ============================================================================
interface unidad_control_pipe_if #(
    parameter int OPW  = 5,
    parameter int ALUW = 3,
    parameter int ILLW = 8
);
    logic [OPW-1:0]  OPCODE;
    logic [ALUW-1:0] ALUOP;
    logic            id_valid;
    logic            stall;
    logic            flush;

    logic            ex_valid;
    logic            mem_valid;
    logic            wb_valid;
    logic [ALUW-1:0] ex_ALUSignal;
    logic            ex_OpbSelect;
    logic            ex_Branch;
    logic            mem_WE;
    logic            mem_SelectMem;
    logic            mem_DataInputS;
    logic            mem_DataInputON;
    logic            wb_RWrite;
    logic            wb_SelectMem;
    logic            ex_illegal;
    logic [ILLW-1:0] illegal_count;

    modport master (
        output OPCODE, ALUOP, id_valid, stall, flush,
        input  ex_valid, mem_valid, wb_valid, ex_ALUSignal, ex_OpbSelect,
               ex_Branch, mem_WE, mem_SelectMem, mem_DataInputS,
               mem_DataInputON, wb_RWrite, wb_SelectMem, ex_illegal,
               illegal_count
    );

    modport slave (
        input  OPCODE, ALUOP, id_valid, stall, flush,
        output ex_valid, mem_valid, wb_valid, ex_ALUSignal, ex_OpbSelect,
               ex_Branch, mem_WE, mem_SelectMem, mem_DataInputS,
               mem_DataInputON, wb_RWrite, wb_SelectMem, ex_illegal,
               illegal_count
    );
endinterface
`default_nettype wire

// File: rtl/unidad_control_pipe.sv
`default_nettype none
// ============================================================================
// Module   : unidad_control_pipe
// Brief    : Pipelined control decoder: decodes in ID and carries the control
//            bundle through EX/MEM/WB with stall, flush and illegal tracking.
// Revision : 1.0 - initial release
// ============================================================================
module unidad_control_pipe #(
    parameter int OPW  = 5,
    parameter int ALUW = 3,
    parameter int ILLW = 8
) (
    input  wire logic            clk,
    input  wire logic            rst,
    unidad_control_pipe_if.slave cu
);
    localparam logic [OPW-1:0] c_OP_RTYPE = OPW'(0);
    localparam logic [OPW-1:0] c_OP_ITYPE = OPW'(1);
    localparam logic [OPW-1:0] c_OP_LOAD  = OPW'(2);
    localparam logic [OPW-1:0] c_OP_STORE = OPW'(3);
    localparam logic [OPW-1:0] c_OP_BRAN  = OPW'(4);
    localparam logic [OPW-1:0] c_OP_INPUT = OPW'(5);

    logic [ALUW-1:0] w_alu;
    logic w_rw, w_sel, w_opb, w_we, w_br, w_dis, w_dion, w_ill;
    logic w_accept;

    logic [ALUW-1:0] r_ex_alu;
    logic r_ex_valid, r_ex_opb, r_ex_br, r_ex_we, r_ex_sel, r_ex_dis, r_ex_dion;
    logic r_ex_rw, r_ex_ill;
    logic r_mem_valid, r_mem_we, r_mem_sel, r_mem_dis, r_mem_dion, r_mem_rw;
    logic r_wb_valid, r_wb_rw, r_wb_sel;
    logic [ILLW-1:0] r_ill_cnt;

    always_comb begin
        w_alu  = '0;
        w_rw   = 1'b0;
        w_sel  = 1'b0;
        w_opb  = 1'b0;
        w_we   = 1'b0;
        w_br   = 1'b0;
        w_dis  = 1'b0;
        w_dion = 1'b0;
        w_ill  = 1'b0;
        case (cu.OPCODE)
            c_OP_RTYPE: begin w_rw = 1'b1; w_alu = cu.ALUOP; end
            c_OP_ITYPE: begin w_rw = 1'b1; w_opb = 1'b1; w_alu = cu.ALUOP; end
            c_OP_LOAD:  begin w_rw = 1'b1; w_sel = 1'b1; w_opb = 1'b1; end
            c_OP_STORE: begin w_we = 1'b1; w_opb = 1'b1; end
            c_OP_BRAN:  begin w_br = 1'b1; w_alu = ALUW'(1); end
            c_OP_INPUT: begin w_rw = 1'b1; w_dis = 1'b1; w_dion = 1'b1; end
            default:    w_ill = 1'b1;
        endcase
    end

    // Stall, flush and empty ID all turn the new EX entry into a bubble.
    assign w_accept = cu.id_valid && !cu.stall && !cu.flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid  <= 1'b0;
            r_ex_alu    <= '0;
            r_ex_opb    <= 1'b0;
            r_ex_br     <= 1'b0;
            r_ex_we     <= 1'b0;
            r_ex_sel    <= 1'b0;
            r_ex_dis    <= 1'b0;
            r_ex_dion   <= 1'b0;
            r_ex_rw     <= 1'b0;
            r_ex_ill    <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_sel   <= 1'b0;
            r_mem_dis   <= 1'b0;
            r_mem_dion  <= 1'b0;
            r_mem_rw    <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_wb_rw     <= 1'b0;
            r_wb_sel    <= 1'b0;
            r_ill_cnt   <= '0;
        end else begin
            r_wb_valid <= r_mem_valid;
            r_wb_rw    <= r_mem_rw;
            r_wb_sel   <= r_mem_sel;

            // A taken branch kills the instruction in EX before it reaches MEM.
            if (cu.flush) begin
                r_mem_valid <= 1'b0;
                r_mem_we    <= 1'b0;
                r_mem_sel   <= 1'b0;
                r_mem_dis   <= 1'b0;
                r_mem_dion  <= 1'b0;
                r_mem_rw    <= 1'b0;
            end else begin
                r_mem_valid <= r_ex_valid;
                r_mem_we    <= r_ex_we;
                r_mem_sel   <= r_ex_sel;
                r_mem_dis   <= r_ex_dis;
                r_mem_dion  <= r_ex_dion;
                r_mem_rw    <= r_ex_rw;
            end

            r_ex_valid <= w_accept;
            r_ex_alu   <= w_accept ? w_alu : '0;
            r_ex_opb   <= w_accept && w_opb;
            r_ex_br    <= w_accept && w_br;
            r_ex_we    <= w_accept && w_we;
            r_ex_sel   <= w_accept && w_sel;
            r_ex_dis   <= w_accept && w_dis;
            r_ex_dion  <= w_accept && w_dion;
            r_ex_rw    <= w_accept && w_rw;
            r_ex_ill   <= w_accept && w_ill;

            if (w_accept && w_ill && !(&r_ill_cnt))
                r_ill_cnt <= r_ill_cnt + 1'b1;
        end
    end

    assign cu.ex_valid        = r_ex_valid;
    assign cu.ex_ALUSignal    = r_ex_alu;
    assign cu.ex_OpbSelect    = r_ex_opb;
    assign cu.ex_Branch       = r_ex_br;
    assign cu.ex_illegal      = r_ex_ill;
    assign cu.mem_valid       = r_mem_valid;
    assign cu.mem_WE          = r_mem_we;
    assign cu.mem_SelectMem   = r_mem_sel;
    assign cu.mem_DataInputS  = r_mem_dis;
    assign cu.mem_DataInputON = r_mem_dion;
    assign cu.wb_valid        = r_wb_valid;
    assign cu.wb_RWrite       = r_wb_rw;
    assign cu.wb_SelectMem    = r_wb_sel;
    assign cu.illegal_count   = r_ill_cnt;
endmodule
`default_nettype wire

// File: tb/tb_unidad_control_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_unidad_control_pipe
// Brief    : Scoreboard bench for unidad_control_pipe (ILLW=8 and ILLW=2 copies).
// Revision : 1.0 - initial release
// ============================================================================
module tb_unidad_control_pipe;
    localparam int OPW  = 5;
    localparam int ALUW = 3;

    typedef struct {
        bit rw, sel, opb, we, br, dis, dion, ill;
        int alu;
    } ctl_t;

    typedef struct {
        bit   v;
        ctl_t c;
    } rec_t;

    typedef struct {
        bit exv, memv, wbv, opb, br, we, msel, dis, dion, rw, wsel, ill;
        int alu, c8, c2;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    unidad_control_pipe_if #(.OPW(OPW), .ALUW(ALUW), .ILLW(8)) b8 ();
    unidad_control_pipe_if #(.OPW(OPW), .ALUW(ALUW), .ILLW(2)) b2 ();

    unidad_control_pipe #(.OPW(OPW), .ALUW(ALUW), .ILLW(8)) dut8 (.clk(clk), .rst(rst), .cu(b8));
    unidad_control_pipe #(.OPW(OPW), .ALUW(ALUW), .ILLW(2)) dut2 (.clk(clk), .rst(rst), .cu(b2));

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    rec_t ex_m, mem_m, wb_m, empty_r;
    int   c8_m, c2_m;

    function automatic ctl_t dec(int op, int a);
        ctl_t c;
        c = '{default: 0};
        case (op)
            0: begin c.rw = 1; c.alu = a; end
            1: begin c.rw = 1; c.opb = 1; c.alu = a; end
            2: begin c.rw = 1; c.sel = 1; c.opb = 1; end
            3: begin c.we = 1; c.opb = 1; end
            4: begin c.br = 1; c.alu = 1; end
            5: begin c.rw = 1; c.dis = 1; c.dion = 1; end
            default: c.ill = 1;
        endcase
        return c;
    endfunction

    task automatic chk(string name, int act, int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // One edge of stimulus: drive after the falling edge, update the model on the rising edge.
    task automatic step(bit r, int op, int a, bit v, bit st, bit fl);
        exp_t e;
        @(negedge clk);
        rst = r;
        b8.OPCODE = OPW'(op); b8.ALUOP = ALUW'(a); b8.id_valid = v; b8.stall = st; b8.flush = fl;
        b2.OPCODE = OPW'(op); b2.ALUOP = ALUW'(a); b2.id_valid = v; b2.stall = st; b2.flush = fl;
        @(posedge clk);
        if (r) begin
            ex_m = empty_r; mem_m = empty_r; wb_m = empty_r; c8_m = 0; c2_m = 0;
        end else begin
            wb_m  = mem_m;
            mem_m = fl ? empty_r : ex_m;
            if (v && !st && !fl) begin
                ex_m.v = 1;
                ex_m.c = dec(op % 32, a % 8);
                if (ex_m.c.ill) begin
                    if (c8_m < 255) c8_m++;
                    if (c2_m < 3)   c2_m++;
                end
            end else begin
                ex_m = empty_r;
            end
        end
        e.exv = ex_m.v;  e.alu = ex_m.c.alu; e.opb = ex_m.c.opb; e.br = ex_m.c.br; e.ill = ex_m.c.ill;
        e.memv = mem_m.v; e.we = mem_m.c.we; e.msel = mem_m.c.sel; e.dis = mem_m.c.dis; e.dion = mem_m.c.dion;
        e.wbv = wb_m.v;  e.rw = wb_m.c.rw;  e.wsel = wb_m.c.sel;
        e.c8 = c8_m; e.c2 = c2_m;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("ex_valid",        int'(b8.ex_valid),        int'(e.exv));
            chk("ex_ALUSignal",    int'(b8.ex_ALUSignal),    e.alu);
            chk("ex_OpbSelect",    int'(b8.ex_OpbSelect),    int'(e.opb));
            chk("ex_Branch",       int'(b8.ex_Branch),       int'(e.br));
            chk("ex_illegal",      int'(b8.ex_illegal),      int'(e.ill));
            chk("mem_valid",       int'(b8.mem_valid),       int'(e.memv));
            chk("mem_WE",          int'(b8.mem_WE),          int'(e.we));
            chk("mem_SelectMem",   int'(b8.mem_SelectMem),   int'(e.msel));
            chk("mem_DataInputS",  int'(b8.mem_DataInputS),  int'(e.dis));
            chk("mem_DataInputON", int'(b8.mem_DataInputON), int'(e.dion));
            chk("wb_valid",        int'(b8.wb_valid),        int'(e.wbv));
            chk("wb_RWrite",       int'(b8.wb_RWrite),       int'(e.rw));
            chk("wb_SelectMem",    int'(b8.wb_SelectMem),    int'(e.wsel));
            chk("illegal_count8",  int'(b8.illegal_count),   e.c8);
            chk("illegal_count2",  int'(b2.illegal_count),   e.c2);
            chk("ex_valid_ill2",   int'(b2.ex_valid),        int'(e.exv));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        empty_r = '{v: 0, c: '{default: 0}};
        ex_m = empty_r; mem_m = empty_r; wb_m = empty_r; c8_m = 0; c2_m = 0;
        rst = 1'b1;
        b8.OPCODE = '0; b8.ALUOP = '0; b8.id_valid = 1'b0; b8.stall = 1'b0; b8.flush = 1'b0;
        b2.OPCODE = '0; b2.ALUOP = '0; b2.id_valid = 1'b0; b2.stall = 1'b0; b2.flush = 1'b0;

        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        // Back-to-back R-type with ALUOP 0..4, then drain.
        for (int i = 0; i < 5; i++) step(0, 0, i, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);

        // One of each legal class.
        for (int op = 1; op <= 5; op++) step(0, op, int'($urandom_range(0, 7)), 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);

        // Load, two stalled cycles holding an R-type, then the R-type enters.
        step(0, 2, 0, 1, 0, 0);
        step(0, 0, 3, 1, 1, 0);
        step(0, 0, 3, 1, 1, 0);
        step(0, 0, 3, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);

        // Branch killed by flush while a stall is also requested.
        step(0, 0, 1, 1, 0, 0);
        step(0, 4, 0, 1, 0, 0);
        step(0, 1, 2, 1, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);

        // Illegal opcodes, one of them presented during a stall.
        step(0, 6, 0, 1, 0, 0);
        step(0, 31, 0, 1, 1, 0);
        step(0, 7, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 6 + (i % 26), 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Pipeline full of loads, reset, then a fresh R-type.
        for (int i = 0; i < 3; i++) step(0, 2, 0, 1, 0, 0);
        step(1, 2, 0, 1, 0, 0);
        step(0, 0, 5, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            int op;
            op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 31)) : int'($urandom_range(0, 5));
            step(($urandom_range(0, 59) == 0), op, int'($urandom_range(0, 7)),
                 ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 9) == 0));
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
